processor: RTL and testbench
============================

PROCESSOR -- requirements
Module: processor

Interface
REQ-001 Parameter: DATA_W, default 8, operand/result width; only 8 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on rising clk).
REQ-004 opcode  input  8  instruction opcode from the instruction loader.
REQ-005 operand1  input  8  first operand (A).
REQ-006 operand2  input  8  second operand (B).
REQ-007 done  input  1  loader finished; high = no further valid instructions.
REQ-008 result  output  8  registered ALU result.
REQ-009 flags  output  4  registered status {N,V,C,Z} = flags[3:0].

Function
REQ-010 The state machine SHALL have two states, RUN and HALTED; reset enters RUN.
REQ-011 In RUN with done=0, each rising edge SHALL sample opcode/operands and update result/flags at that same edge (1-cycle latency, one instruction per cycle, no stall).
REQ-012 In RUN with done=1, the instruction inputs SHALL be ignored and the state SHALL become HALTED at that edge.
REQ-013 HALTED SHALL hold result and flags unchanged and ignore all inputs until reset.
REQ-014 Opcodes: 0x00 NOP; 0x01 ADD A+B; 0x02 SUB A-B; 0x03 AND; 0x04 OR; 0x05 XOR; 0x06 NOT A; 0x07 SHL A by B[2:0]; 0x08 SHR (logical) A by B[2:0]; 0x09 MUL low 8 bits of A*B; 0x0A CMP (A-B, flags only); 0xFF HALT (same as done=1).
REQ-015 NOP and any undefined opcode SHALL leave result and flags unchanged.
REQ-016 Z = (8-bit result == 0); N = result[7]; both SHALL be updated by every result-writing opcode and by CMP.
REQ-017 ADD: C = carry out of bit 7; V = signed overflow (A[7]==B[7] and result[7]!=A[7]).
REQ-018 SUB/CMP: C = borrow (1 when A < B unsigned); V = signed overflow (A[7]!=B[7] and result[7]!=A[7]).
REQ-019 Logic ops, NOT and MUL: C=0, V=0; shifts: C = last bit shifted out (0 when shift amount is 0), V=0.
REQ-020 CMP SHALL NOT modify result.
REQ-021 All arithmetic SHALL wrap modulo 256; no saturation.

Reset
REQ-022 With reset=0 at a rising edge: result=0x00, flags=0x0, state=RUN, regardless of current state.
REQ-023 Reset SHALL take priority over done and any opcode in the same cycle; an instruction presented during reset SHALL be discarded.

Configuration
REQ-024 Macro SIM_FINISH_EN: when defined, the module SHALL print result/flags and call $finish on the first edge after entering HALTED (simulation only); when undefined, no simulation tasks are compiled and the block stays HALTED until reset.

Structure
REQ-025 A shared package processor_pkg SHALL hold the opcode constants/enum, the flag bit indices (Z=0,C=1,V=2,N=3) and the state enum.
REQ-026 The combinational ALU SHALL be one sub-module, processor_alu (inputs opcode/A/B/old flags, outputs next result, next flags, write enable); state and registers stay in processor.

Verification
REQ-027 ADD A=0x7F B=0x01 -> result 0x80, flags N=1 V=1 C=0 Z=0 one edge later.
REQ-028 ADD A=0xFF B=0x01 -> result 0x00, Z=1 C=1 N=0 V=0; then SUB A=0x03 B=0x05 -> result 0xFE, C=1 N=1 Z=0.
REQ-029 CMP A=0x05 B=0x05 after result=0x22 -> result stays 0x22, Z=1 C=0; undefined opcode 0x42 -> result and flags unchanged.
REQ-030 SHL A=0x81 B=0x01 -> result 0x02, C=1; MUL A=0x10 B=0x11 -> result 0x10, C=0 V=0.
REQ-031 done=1 with opcode ADD 0x01,0x01 present -> result unchanged, state HALTED; later ADD with done=0 still ignored; with SIM_FINISH_EN, $finish on next edge.
REQ-032 reset=0 mid-stream (after result=0x80) -> result 0x00 flags 0x0 next edge; after release, ADD 0x02+0x03 -> 0x05.

Source files
------------

// File: rtl/processor_pkg.sv
// -----------------------------------------------------------------------------
// processor_pkg
// Shared definitions for the single-cycle processor: opcode encodings, the
// bit positions of the status flags inside the 4-bit flags word, and the
// run/halt state encoding.
// Optional build macro used by the top: SIM_FINISH_EN.
// -----------------------------------------------------------------------------
package processor_pkg;

  typedef enum logic [7:0] {
    OP_NOP  = 8'h00,
    OP_ADD  = 8'h01,
    OP_SUB  = 8'h02,
    OP_AND  = 8'h03,
    OP_OR   = 8'h04,
    OP_XOR  = 8'h05,
    OP_NOT  = 8'h06,
    OP_SHL  = 8'h07,
    OP_SHR  = 8'h08,
    OP_MUL  = 8'h09,
    OP_CMP  = 8'h0A,
    OP_HALT = 8'hFF
  } opcode_e;

  // Flag word layout is {N,V,C,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/processor_alu.sv
// -----------------------------------------------------------------------------
// processor_alu
// Purely combinational ALU. Produces the next result and next flags for one
// instruction plus separate write enables, so the caller can keep result
// untouched for CMP and leave everything untouched for NOP/undefined codes.
// Ports:
//   i_opcode      instruction opcode
//   i_a, i_b      operands A and B
//   i_flags       current flags {N,V,C,Z} (passed through when not written)
//   o_result      next result value (valid when o_res_we)
//   o_flags       next flags value
//   o_res_we      result register should load o_result
//   o_flags_we    flags register should load o_flags
// -----------------------------------------------------------------------------
module processor_alu
  import processor_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [7:0]        i_opcode,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [3:0]        i_flags,
  output logic [DATA_W-1:0] o_result,
  output logic [3:0]        o_flags,
  output logic              o_res_we,
  output logic              o_flags_we
);

  opcode_e            w_op;
  logic [DATA_W:0]    w_sum;
  logic [DATA_W:0]    w_diff;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W:0]    w_shl;
  logic [DATA_W:0]    w_shr;
  logic [2:0]         w_shamt;
  logic [DATA_W-1:0]  w_res;
  logic               w_c;
  logic               w_v;

  assign w_op    = opcode_e'(i_opcode);
  assign w_shamt = i_b[2:0];
  assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
  // Bit DATA_W of the extended difference is the borrow (A < B unsigned)
  assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
  assign w_prod  = i_a * i_b;
  // Extra bit above the MSB catches the last bit shifted out on the left
  assign w_shl   = {1'b0, i_a} << w_shamt;
  // Extra bit below the LSB catches the last bit shifted out on the right
  assign w_shr   = {i_a, 1'b0} >> w_shamt;

  always_comb begin
    w_res      = '0;
    w_c        = 1'b0;
    w_v        = 1'b0;
    o_res_we   = 1'b0;
    o_flags_we = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res      = w_sum[DATA_W-1:0];
        w_c        = w_sum[DATA_W];
        w_v        = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
                     (w_sum[DATA_W-1] != i_a[DATA_W-1]);
        o_res_we   = 1'b1;
        o_flags_we = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        w_res      = w_diff[DATA_W-1:0];
        w_c        = w_diff[DATA_W];
        w_v        = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
                     (w_diff[DATA_W-1] != i_a[DATA_W-1]);
        o_res_we   = (w_op == OP_SUB);
        o_flags_we = 1'b1;
      end
      OP_AND: begin
        w_res      = i_a & i_b;
        o_res_we   = 1'b1;
        o_flags_we = 1'b1;
      end
      OP_OR: begin
        w_res      = i_a | i_b;
        o_res_we   = 1'b1;
        o_flags_we = 1'b1;
      end
      OP_XOR: begin
        w_res      = i_a ^ i_b;
        o_res_we   = 1'b1;
        o_flags_we = 1'b1;
      end
      OP_NOT: begin
        w_res      = ~i_a;
        o_res_we   = 1'b1;
        o_flags_we = 1'b1;
      end
      OP_SHL: begin
        w_res      = w_shl[DATA_W-1:0];
        w_c        = w_shl[DATA_W];
        o_res_we   = 1'b1;
        o_flags_we = 1'b1;
      end
      OP_SHR: begin
        w_res      = w_shr[DATA_W:1];
        w_c        = w_shr[0];
        o_res_we   = 1'b1;
        o_flags_we = 1'b1;
      end
      OP_MUL: begin
        w_res      = w_prod[DATA_W-1:0];
        o_res_we   = 1'b1;
        o_flags_we = 1'b1;
      end
      default: begin
        // NOP, HALT and undefined codes write nothing
      end
    endcase
  end

  assign o_result = w_res;

  always_comb begin
    o_flags = i_flags;
    if (o_flags_we) begin
      o_flags[FLAG_N] = w_res[DATA_W-1];
      o_flags[FLAG_V] = w_v;
      o_flags[FLAG_C] = w_c;
      o_flags[FLAG_Z] = (w_res == '0);
    end
  end

endmodule

// File: rtl/processor.sv
// -----------------------------------------------------------------------------
// processor
// Single-cycle instruction executor with a RUN/HALTED state machine. In RUN
// every rising edge executes the presented instruction (1-cycle latency);
// done=1 or the HALT opcode moves to HALTED, where result/flags freeze until
// reset.
// Optional build macro: SIM_FINISH_EN -- when defined, the first edge spent
// in HALTED prints result/flags and ends the simulation.
// Ports:
//   clk       clock, rising edge
//   reset     synchronous reset, active low
//   opcode    instruction opcode
//   operand1  operand A
//   operand2  operand B
//   done      loader finished (no more valid instructions)
//   result    registered result
//   flags     registered {N,V,C,Z}
// -----------------------------------------------------------------------------
module processor
  import processor_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        opcode,
  input  logic [DATA_W-1:0] operand1,
  input  logic [DATA_W-1:0] operand2,
  input  logic              done,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  state_e            r_state;
  logic [DATA_W-1:0] r_result;
  logic [3:0]        r_flags;

  logic [DATA_W-1:0] w_alu_result;
  logic [3:0]        w_alu_flags;
  logic              w_res_we;
  logic              w_flags_we;
  logic              w_halt_req;

  processor_alu #(.DATA_W(DATA_W)) u_alu (
    .i_opcode   (opcode),
    .i_a        (operand1),
    .i_b        (operand2),
    .i_flags    (r_flags),
    .o_result   (w_alu_result),
    .o_flags    (w_alu_flags),
    .o_res_we   (w_res_we),
    .o_flags_we (w_flags_we)
  );

  assign w_halt_req = done || (opcode == OP_HALT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_RUN;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_halt_req) begin
            // Instruction presented alongside done/HALT is discarded
            r_state <= ST_HALTED;
          end else begin
            if (w_res_we)   r_result <= w_alu_result;
            if (w_flags_we) r_flags  <= w_alu_flags;
          end
        end
        default: begin
          r_state <= ST_HALTED;
        end
      endcase
    end
  end

  assign result = r_result;
  assign flags  = r_flags;

`ifdef SIM_FINISH_EN
  always @(posedge clk) begin
    if (reset && (r_state == ST_HALTED)) begin
      $display("processor halted: result=%02h flags=%01h", r_result, r_flags);
      $finish;
    end
  end
`else
`endif

endmodule

// File: tb/tb_processor.sv
// -----------------------------------------------------------------------------
// tb_processor
// Scoreboard bench: each driven instruction pushes the reference model's
// expected {result,flags} into a queue; after the edge the entry is popped
// and compared against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_processor;

  logic       clk;
  logic       reset;
  logic [7:0] opcode;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic       done;
  logic [7:0] result;
  logic [3:0] flags;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [7:0] m_res;
  logic [3:0] m_flg;
  bit         m_halt;

  processor #(.DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .operand1 (operand1),
    .operand2 (operand2),
    .done     (done),
    .result   (result),
    .flags    (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer-arithmetic reference for one instruction; returns {res, flags}
  function automatic logic [11:0] model_alu(input logic [7:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] r_old,
                                            input logic [3:0] f_old);
    int ia, ib, sa, sb, full, sv, s;
    logic [7:0] r;
    logic c, v;
    ia = int'(a); ib = int'(b);
    sa = a[7] ? ia - 256 : ia;
    sb = b[7] ? ib - 256 : ib;
    s  = ib % 8;
    c  = 1'b0; v = 1'b0; r = 8'h00;
    case (op)
      8'h01: begin full = ia + ib; r = 8'(full % 256); c = (full > 255);
                   sv = sa + sb; v = (sv > 127) || (sv < -128); end
      8'h02, 8'h0A: begin full = ia - ib; r = 8'((full + 256) % 256); c = (ia < ib);
                   sv = sa - sb; v = (sv > 127) || (sv < -128); end
      8'h03: r = a & b;
      8'h04: r = a | b;
      8'h05: r = a ^ b;
      8'h06: r = ~a;
      8'h07: begin r = 8'((ia << s) % 256); c = (s != 0) ? 1'((ia >> (8 - s)) & 1) : 1'b0; end
      8'h08: begin r = 8'(ia >> s); c = (s != 0) ? 1'((ia >> (s - 1)) & 1) : 1'b0; end
      8'h09: r = 8'((ia * ib) % 256);
      default: return {r_old, f_old};
    endcase
    return {(op == 8'h0A) ? r_old : r, r[7], v, c, (r == 8'h00)};
  endfunction

  // Drive one cycle of stimulus, advance the model, and queue its expectation
  task automatic drive(input logic rst_n, input logic [7:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic dn, input string nm);
    logic [11:0] nxt;
    exp_t e;
    @(negedge clk);
    reset = rst_n; opcode = op; operand1 = a; operand2 = b; done = dn;
    if (!rst_n) begin
      m_res = 8'h00; m_flg = 4'h0; m_halt = 1'b0;
    end else if (!m_halt) begin
      if (dn || op == 8'hFF) m_halt = 1'b1;
      else begin
        nxt = model_alu(op, a, b, m_res, m_flg);
        m_res = nxt[11:4]; m_flg = nxt[3:0];
      end
    end
    e.res = m_res; e.flg = m_flg; e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'h01, 8'h11, 8'h22, 1'b0, "reset");
      e = exp_q.pop_front();
      n_tests++;
      if (result !== e.res || flags !== e.flg) begin
        n_fail++;
        $display("FAIL %s: got res=%02h flg=%01h, expected res=%02h flg=%01h", e.name, result, flags, e.res, e.flg);
      end
    end
    n_tests++;
    if (result !== 8'h00 || flags !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_const: got res=%02h flg=%01h, expected 00/0", result, flags);
    end
  endtask

  task automatic test_arith();
    exp_t e;
    logic [7:0] ops[3] = '{8'h01, 8'h01, 8'h02};
    logic [7:0] as[3]  = '{8'h7F, 8'hFF, 8'h03};
    logic [7:0] bs[3]  = '{8'h01, 8'h01, 8'h05};
    logic [7:0] kr[3]  = '{8'h80, 8'h00, 8'hFE};
    logic [3:0] kf[3]  = '{4'hC, 4'h3, 4'hA};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ops[i], as[i], bs[i], 1'b0, "arith");
      e = exp_q.pop_front();
      n_tests++;
      if (result !== e.res || flags !== e.flg) begin
        n_fail++;
        $display("FAIL %s[%0d]: got res=%02h flg=%01h, expected res=%02h flg=%01h", e.name, i, result, flags, e.res, e.flg);
      end
      n_tests++;
      if (result !== kr[i] || flags !== kf[i]) begin
        n_fail++;
        $display("FAIL arith_const[%0d]: got res=%02h flg=%01h, expected res=%02h flg=%01h", i, result, flags, kr[i], kf[i]);
      end
    end
  endtask

  task automatic test_cmp_undef();
    exp_t e;
    logic [7:0] ops[4] = '{8'h01, 8'h0A, 8'h42, 8'h00};
    logic [7:0] as[4]  = '{8'h20, 8'h05, 8'h99, 8'h77};
    logic [7:0] bs[4]  = '{8'h02, 8'h05, 8'h11, 8'h66};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ops[i], as[i], bs[i], 1'b0, "cmp_undef");
      e = exp_q.pop_front();
      n_tests++;
      if (result !== e.res || flags !== e.flg) begin
        n_fail++;
        $display("FAIL %s[%0d]: got res=%02h flg=%01h, expected res=%02h flg=%01h", e.name, i, result, flags, e.res, e.flg);
      end
      if (i > 0) begin
        n_tests++;
        if (result !== 8'h22 || flags !== 4'h1) begin
          n_fail++;
          $display("FAIL cmp_const[%0d]: got res=%02h flg=%01h, expected res=22 flg=1", i, result, flags);
        end
      end
    end
  endtask

  task automatic test_logic_shift();
    exp_t e;
    logic [7:0] ops[10] = '{8'h07, 8'h09, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08, 8'h08, 8'h07, 8'h07};
    logic [7:0] as[10]  = '{8'h81, 8'h10, 8'hF0, 8'h0F, 8'hAA, 8'hFF, 8'h81, 8'h05, 8'h81, 8'h01};
    logic [7:0] bs[10]  = '{8'h01, 8'h11, 8'h0F, 8'hF0, 8'hAA, 8'h00, 8'h01, 8'hF8, 8'h07, 8'h1F};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, ops[i], as[i], bs[i], 1'b0, "logic_shift");
      e = exp_q.pop_front();
      n_tests++;
      if (result !== e.res || flags !== e.flg) begin
        n_fail++;
        $display("FAIL %s[%0d]: got res=%02h flg=%01h, expected res=%02h flg=%01h", e.name, i, result, flags, e.res, e.flg);
      end
      if (i == 0) begin
        n_tests++;
        if (result !== 8'h02 || flags[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL shl_const: got res=%02h C=%b, expected res=02 C=1", result, flags[1]);
        end
      end
      if (i == 1) begin
        n_tests++;
        if (result !== 8'h10 || flags !== 4'h0) begin
          n_fail++;
          $display("FAIL mul_const: got res=%02h flg=%01h, expected res=10 flg=0", result, flags);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] op;
    for (int i = 0; i < 40; i++) begin
      op = (i % 9 == 8) ? 8'h42 : 8'($urandom_range(0, 10));
      drive(1'b1, op, 8'($urandom), 8'($urandom), 1'b0, "random");
      e = exp_q.pop_front();
      n_tests++;
      if (result !== e.res || flags !== e.flg) begin
        n_fail++;
        $display("FAIL %s[%0d] op=%02h: got res=%02h flg=%01h, expected res=%02h flg=%01h", e.name, i, op, result, flags, e.res, e.flg);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [7:0] ops[3] = '{8'h01, 8'h01, 8'h01};
    logic [7:0] as[3]  = '{8'h7F, 8'h40, 8'h02};
    logic [7:0] bs[3]  = '{8'h01, 8'h40, 8'h03};
    logic       rs[3]  = '{1'b1, 1'b0, 1'b1};
    logic [7:0] kr[3]  = '{8'h80, 8'h00, 8'h05};
    for (int i = 0; i < 3; i++) begin
      drive(rs[i], ops[i], as[i], bs[i], (i == 1), "reset_mid");
      e = exp_q.pop_front();
      n_tests++;
      if (result !== e.res || flags !== e.flg) begin
        n_fail++;
        $display("FAIL %s[%0d]: got res=%02h flg=%01h, expected res=%02h flg=%01h", e.name, i, result, flags, e.res, e.flg);
      end
      n_tests++;
      if (result !== kr[i]) begin
        n_fail++;
        $display("FAIL reset_mid_const[%0d]: got res=%02h, expected res=%02h", i, result, kr[i]);
      end
    end
  endtask

  task automatic test_halt();
    exp_t e;
    logic [7:0] ops[7] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'hFF, 8'h01};
    logic [7:0] as[7]  = '{8'h01, 8'h10, 8'h33, 8'h00, 8'h04, 8'h01, 8'h01};
    logic [7:0] bs[7]  = '{8'h01, 8'h20, 8'h44, 8'h01, 8'h04, 8'h01, 8'h01};
    logic       dn[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       rs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(rs[i], ops[i], as[i], bs[i], dn[i], "halt");
      e = exp_q.pop_front();
      n_tests++;
      if (result !== e.res || flags !== e.flg) begin
        n_fail++;
        $display("FAIL %s[%0d]: got res=%02h flg=%01h, expected res=%02h flg=%01h", e.name, i, result, flags, e.res, e.flg);
      end
      if (i < 3) begin
        n_tests++;
        if (result !== 8'h05) begin
          n_fail++;
          $display("FAIL halt_hold[%0d]: got res=%02h, expected res=05", i, result);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; opcode = 8'h00; operand1 = 8'h00; operand2 = 8'h00; done = 1'b0;
    m_res = 8'h00; m_flg = 4'h0; m_halt = 1'b0;
    test_reset();
    test_arith();
    test_cmp_undef();
    test_logic_shift();
    test_back_to_back();
    test_reset_mid();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
